nibble_serial_adder: RTL
========================

Name: nibble_serial_adder

Overview:
- Multi-cycle W-bit adder/subtractor for area-constrained datapath slots. Reuses a single rca_4b instance over W/4 cycles, one nibble per cycle, least-significant nibble first.
- Sits directly upstream of the rca_4b slice: it feeds the slice its operand nibbles and carry-in, then consumes its sum and C_out.
- Presents a start/busy/done handshake to the ALU sequencer and holds the W-bit result plus flags until the next completion.

Parameters:
- W, 16, operand/result width; must be a multiple of 4 and >= 4.
- NIB, W/4, number of nibble passes (derived, not overridden).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- sub  input  1  1 = A - B, 0 = A + B; sampled with start.
- A  input  W  operand A; sampled with start.
- B  input  W  operand B; sampled with start.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; result registers valid from this cycle.
- Sum  output  W  result, held until next completion.
- Cout  output  1  carry out of MSB. For subtract, 1 = no borrow.
- Ovfl  output  1  signed two's-complement overflow of the completed operation.
- Zero  output  1  Sum == 0.

Behaviour:
- States: IDLE, RUN, DONE. State register plus nibble counter of ceil(log2(NIB)) bits, minimum 1 bit.
- Reset (rst_n low, asynchronous): state=IDLE, counter=0, carry=0, operand and partial registers cleared. busy=0, done=0, Sum=0, Cout=0, Ovfl=0, Zero=0.
- IDLE, start=1 at edge k:
  - latch a_sh=A and b_sh=(sub ? ~B : B);
  - latch carry=sub, a_msb=A[W-1], b_msb=(sub ? ~B[W-1] : B[W-1]);
  - counter=0; go to RUN.
- IDLE, start=0: hold.
- RUN, each cycle:
  - rca_4b receives A=a_sh[3:0], B=b_sh[3:0], C_in=carry.
  - At the edge: partial shifts right 4 with the slice S in bits [W-1:W-4]; a_sh and b_sh shift right 4; carry=C_out; counter+1.
- RUN exit: on the edge where counter==NIB-1:
  - load Sum with the final partial, i.e. {S, partial[W-1:4]};
  - Cout=C_out;
  - Ovfl=(a_msb==b_msb) && (new Sum[W-1] != a_msb);
  - Zero=(new Sum==0);
  - go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Latency: start sampled at edge k means RUN occupies cycles k+1..k+NIB and done is high in cycle k+NIB+1. For W=16, done is high 5 cycles after start.
- Back-to-back: start in the DONE cycle is ignored. The earliest accepted start is the first IDLE cycle, giving a throughput of one op per NIB+2 cycles.
- start while busy: ignored entirely. In-flight operands, carry and result are unaffected.
- Sum/Cout/Ovfl/Zero change only on the RUN->DONE edge or reset. Intermediate nibbles are never visible on Sum.
- Arithmetic is modulo 2^W. No saturation.
- Reset asserted mid-RUN: immediate return to IDLE with all outputs 0. No done pulse for the aborted op.
- A, B and sub may change freely after the start edge. Only latched copies are used.

Test Plan:
- A=0x1234, B=0x4321, sub=0, start pulse -> busy high for 5 cycles, done in cycle k+5; Sum=0x5555, Cout=0, Ovfl=0, Zero=0.
- A=0xFFFF, B=0x0001, sub=0 -> Sum=0x0000, Cout=1, Zero=1, Ovfl=0. Confirms the carry ripples across all 4 nibble passes.
- A=0x7FFF, B=0x0001, sub=0 -> Sum=0x8000, Ovfl=1, Cout=0. Then A=0x8000, B=0x0001, sub=1 -> Sum=0x7FFF, Ovfl=1, Cout=1.
- A=0x0005, B=0x0007, sub=1 -> Sum=0xFFFE, Cout=0 (borrow), Ovfl=0. Also A=B=0x1234, sub=1 -> Sum=0, Zero=1, Cout=1.
- Start 0x0001+0x0001, then hold start=1 with A=0xAAAA through RUN and the DONE cycle -> first result 0x0002 unaffected, no second op accepted until IDLE. The second op then completes as a normal 5-cycle sequence.
- Drop rst_n mid-RUN during cycle k+2 -> outputs 0 immediately, no done pulse. After release, 0x00F0+0x0F10 -> Sum=0x1000, done after 5 cycles.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// W-bit add/subtract that time-multiplexes one 4-bit ripple-carry slice, LS nibble first.
// A start/busy/done handshake is presented to the sequencer; the result and flags are held until the next completion.

module rca_4b (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       C_in,
    output logic [3:0] S,
    output logic       C_out
);
    logic [4:0] c;

    always_comb begin
        c    = '0;
        c[0] = C_in;
        S    = '0;
        for (int i = 0; i < 4; i++) begin
            S[i]   = A[i] ^ B[i] ^ c[i];
            c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
        end
        C_out = c[4];
    end
endmodule

module nibble_serial_adder #(
    parameter int W   = 16,
    parameter int NIB = W / 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] Sum,
    output logic         Cout,
    output logic         Ovfl,
    output logic         Zero
);
    localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           carry_q, carry_d;
    logic [W-1:0]   a_sh_q, a_sh_d, b_sh_q, b_sh_d;
    logic           a_msb_q, a_msb_d, b_msb_q, b_msb_d;
    logic [W-1:0]   part_q, part_d;
    logic [W-1:0]   sum_q, sum_d;
    logic           cout_q, cout_d, ovfl_q, ovfl_d, zero_q, zero_d;

    logic [3:0]     s_nib;
    logic           c_out;
    logic [W+3:0]   part_wide;
    logic [W-1:0]   part_nxt;

    rca_4b u_rca (
        .A     (a_sh_q[3:0]),
        .B     (b_sh_q[3:0]),
        .C_in  (carry_q),
        .S     (s_nib),
        .C_out (c_out)
    );

    // New nibble enters at the top; after NIB passes the partial is the full result.
    assign part_wide = {s_nib, part_q};
    assign part_nxt  = part_wide[W+3:4];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        part_d  = part_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovfl_d  = ovfl_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: if (start) begin
                a_sh_d  = A;
                b_sh_d  = sub ? ~B : B;
                carry_d = sub;
                a_msb_d = A[W-1];
                b_msb_d = sub ? ~B[W-1] : B[W-1];
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                part_d  = part_nxt;
                a_sh_d  = a_sh_q >> 4;
                b_sh_d  = b_sh_q >> 4;
                carry_d = c_out;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    sum_d   = part_nxt;
                    cout_d  = c_out;
                    ovfl_d  = (a_msb_q == b_msb_q) && (part_nxt[W-1] != a_msb_q);
                    zero_d  = (part_nxt == '0);
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            part_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovfl_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            part_q  <= part_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovfl_q  <= ovfl_d;
            zero_q  <= zero_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign Sum  = sum_q;
    assign Cout = cout_q;
    assign Ovfl = ovfl_q;
    assign Zero = zero_q;
endmodule
